mem_arbiter: RTL

- Shares the single-port instruction/data memory between two requesters: the fetch stage (read-only) and the load/store unit (read/write).
- Sits between the CPU sequencer and the memory block.
- Arbitrates between requests, drives the memory strobes, waits out the read latency and returns a registered response to the winning requester.
- Only one transaction is outstanding at a time.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Contents: default widths and latency, the FSM state encoding, the
// requester IDs, and a helper that returns the other requester.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF     = 14;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned RD_LATENCY_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    // Return the requester that is not id (round-robin tie-break).
    function automatic req_id_e req_other(input req_id_e id);
        return (id == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester and memory signals around mem_arbiter.
// Modports:
//   slave  - the arbiter's view: requests and memory read data come in,
//            grants, responses and memory strobes go out.
//   master - the environment's view (fetch stage, LSU, memory).
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    // Fetch requester
    logic              i_f_req;
    logic [ADDR_W-1:0] i_f_addr;
    logic              o_f_gnt;
    logic              o_f_rvalid;
    // Data (load/store) requester
    logic              i_d_req;
    logic              i_d_we;
    logic [ADDR_W-1:0] i_d_addr;
    logic [DATA_W-1:0] i_d_wdata;
    logic              o_d_gnt;
    logic              o_d_rvalid;
    // Shared response and status
    logic [DATA_W-1:0] o_rdata;
    logic              o_busy;
    // Memory side
    logic              o_mem_read;
    logic              o_mem_write;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_f_req, i_f_addr,
        input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
        input  i_mem_rdata,
        output o_f_gnt, o_f_rvalid, o_d_gnt, o_d_rvalid,
        output o_rdata, o_busy,
        output o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_f_req, i_f_addr,
        output i_d_req, i_d_we, i_d_addr, i_d_wdata,
        output i_mem_rdata,
        input  o_f_gnt, o_f_rvalid, o_d_gnt, o_d_rvalid,
        input  o_rdata, o_busy,
        input  o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Ports:
//   f_req_i  - fetch request
//   d_req_i  - data request
//   last_i   - requester granted most recently (used only in round-robin)
//   winner_o - selected requester
//   valid_o  - at least one request is present
// Build option: MEM_ARBITER_ROUND_ROBIN_EN selects round-robin tie-break;
// otherwise data always beats fetch.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic    f_req_i,
    input  logic    d_req_i,
    input  req_id_e last_i,
    output req_id_e winner_o,
    output logic    valid_o
);

    // Single requester wins outright; a tie goes by policy.
    always_comb begin
        valid_o  = f_req_i | d_req_i;
        winner_o = REQ_DATA;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (f_req_i && d_req_i) begin
            winner_o = req_other(last_i);
        end else if (f_req_i) begin
            winner_o = REQ_FETCH;
        end
`else
        if (f_req_i && !d_req_i) begin
            winner_o = REQ_FETCH;
        end
`endif
    end

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
    // Fixed priority ignores the pointer.
    req_id_e unused_last;
    assign unused_last = last_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing a single-port memory between the fetch stage (read only)
// and the load/store unit (read/write). One transaction is outstanding at
// a time: IDLE/RESP arbitrate, ISSUE strobes memory for one cycle, WAIT
// counts out the read latency, RESP returns a one-cycle rvalid pulse.
// Ports:
//   i_clk, i_reset - clock, synchronous active-high reset
//   bus            - mem_arbiter_if.slave: requester handshakes, shared
//                    o_rdata/o_busy, memory strobes/address/data
// Parameters: ADDR_W, DATA_W, RD_LATENCY (>= 1).
// Build option: MEM_ARBITER_ROUND_ROBIN_EN adds a last-winner pointer
// that breaks ties in favour of the requester not granted last.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic         i_clk,
    input  logic         i_reset,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    req_id_e           owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              f_gnt_q;
    logic              d_gnt_q;
    logic              f_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              busy_q;

    req_id_e           pick_winner;
    logic              pick_valid;
    req_id_e           last_ptr;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    req_id_e           last_q;
    assign last_ptr = last_q;
`else
    assign last_ptr = REQ_DATA;
`endif

    mem_arbiter_pick u_pick (
        .f_req_i  (bus.i_f_req),
        .d_req_i  (bus.i_d_req),
        .last_i   (last_ptr),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    // Main FSM; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= REQ_FETCH;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            f_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q      <= REQ_DATA;
`endif
        end else begin
            // Pulses default low; each state raises only what it owns.
            f_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            f_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;

            case (state_q)
                // RESP arbitrates exactly like IDLE so grants can chain.
                IDLE, RESP: begin
                    if (pick_valid) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        owner_q <= pick_winner;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_q  <= pick_winner;
`endif
                        if (pick_winner == REQ_DATA) begin
                            d_gnt_q     <= 1'b1;
                            we_q        <= bus.i_d_we;
                            addr_q      <= bus.i_d_addr;
                            wdata_q     <= bus.i_d_wdata;
                            mem_read_q  <= ~bus.i_d_we;
                            mem_write_q <= bus.i_d_we;
                        end else begin
                            f_gnt_q     <= 1'b1;
                            we_q        <= 1'b0;
                            addr_q      <= bus.i_f_addr;
                            wdata_q     <= '0;
                            mem_read_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= CNT_W'(RD_LATENCY);
                end

                // Memory data is valid while the counter reads 1.
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        rdata_q <= we_q ? '0 : bus.i_mem_rdata;
                        if (owner_q == REQ_DATA) begin
                            d_rvalid_q <= 1'b1;
                        end else begin
                            f_rvalid_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_f_gnt     = f_gnt_q;
    assign bus.o_d_gnt     = d_gnt_q;
    assign bus.o_f_rvalid  = f_rvalid_q;
    assign bus.o_d_rvalid  = d_rvalid_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_mem_read  = mem_read_q;
    assign bus.o_mem_write = mem_write_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;

endmodule
